// File: rtl/spi_packet_scheduler.sv
// spi_packet_scheduler: 2:1 x 2:1 downsample, pack LINES pixels per packet, buffer and hand packets to the SPI sender.
// Latency: packet pushed 1 cycle after its last accept; trigger at least 2 cycles after push. Option: PKT_FRAME_HEADER_EN.
// Backpressure: none upstream (full FIFO drops the new packet, counted); sender paced by trigger/busy handshake with timeout.

module spi_pkt_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             push_drop
);
    // Generic packet FIFO: show-ahead head, pointer-only reset.
    // Latency: pushed entry visible at head one cycle after the push.
    // Backpressure: a push while full is refused unless a pop happens in the same cycle.
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign head_vld  = (wr_ptr != rd_ptr);
    assign pop_ok    = pop & head_vld;
    assign push_ok   = push_vld & (~full | pop_ok);
    assign push_drop = push_vld & ~push_ok;
    assign head_dat  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

module spi_packet_scheduler #(
    parameter int                    LINES       = 6,
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    FIFO_DEPTH  = 4,
    parameter int                    ACK_TIMEOUT = 4,
    parameter logic [DATA_WIDTH-1:0] HEADER_WORD = 16'hA5A5
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         enable_in,
    input  logic                         pixel_valid_in,
    input  logic [DATA_WIDTH-1:0]        pixel_data_in,
    input  logic [10:0]                  hcount_in,
    input  logic [9:0]                   vcount_in,
    input  logic                         spi_busy_in,
    output logic                         spi_trigger_out,
    output logic [LINES*DATA_WIDTH-1:0]  spi_data_out,
    output logic                         frame_start_out,
    output logic [15:0]                  pkt_count_out,
    output logic [7:0]                   drop_count_out,
    output logic                         ack_err_out
);
    localparam int PW = LINES * DATA_WIDTH;
    localparam int CW = $clog2(LINES);
    localparam int TW = $clog2(ACK_TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    logic          accept;
    logic          frame_hit;
    logic [CW-1:0] lane_idx;
    logic [CW-1:0] pack_cnt;
    logic [PW-1:0] pack_dat;
    logic [PW-1:0] pack_nxt;
    logic          pkt_done;
    logic          pix_vld;
    logic [PW-1:0] pix_dat;
    logic          push_vld;
    logic [PW-1:0] push_dat;
    logic          push_drop;
    logic          head_vld;
    logic [PW-1:0] head_dat;
    logic          pop;
    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] ack_cnt;
    logic          ack_timeout;
    logic          xfer_done;

    assign accept    = pixel_valid_in & enable_in & ~hcount_in[0] & ~vcount_in[0];
    assign frame_hit = accept & (hcount_in == '0) & (vcount_in == '0);
    // Origin pixel restarts packing in the top lane, silently discarding any partial packet.
    assign lane_idx  = frame_hit ? '0 : pack_cnt;
    assign pkt_done  = accept & (lane_idx == CW'(LINES - 1));

    always_comb begin
        pack_nxt = pack_dat;
        for (int i = 0; i < LINES; i++) begin
            if (lane_idx == CW'(i)) pack_nxt[PW-1-i*DATA_WIDTH -: DATA_WIDTH] = pixel_data_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pack_cnt        <= '0;
            pack_dat        <= '0;
            pix_vld         <= 1'b0;
            pix_dat         <= '0;
            frame_start_out <= 1'b0;
        end else begin
            if (accept) begin
                pack_dat <= pack_nxt;
                pack_cnt <= pkt_done ? '0 : lane_idx + 1'b1;
            end
            pix_vld         <= pkt_done;
            if (pkt_done) pix_dat <= pack_nxt;
            frame_start_out <= frame_hit;
        end
    end

`ifdef PKT_FRAME_HEADER_EN
    logic          hdr_vld;
    logic [15:0]   frame_ctr;
    logic [PW-1:0] hdr_dat;

    always_comb begin
        hdr_dat                  = {LINES{HEADER_WORD}};
        hdr_dat[DATA_WIDTH-1:0]  = DATA_WIDTH'(frame_ctr);
    end

    // Header push lands the cycle after the origin accept, ahead of that frame's first pixel packet.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hdr_vld   <= 1'b0;
            frame_ctr <= '0;
        end else begin
            hdr_vld <= frame_hit;
            if (hdr_vld) frame_ctr <= frame_ctr + 16'd1;
        end
    end

    assign push_vld = pix_vld | hdr_vld;
    assign push_dat = hdr_vld ? hdr_dat : pix_dat;
`else
    assign push_vld = pix_vld;
    assign push_dat = pix_dat;
`endif

    spi_pkt_fifo #(
        .WIDTH (PW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push_vld  (push_vld),
        .push_dat  (push_dat),
        .pop       (pop),
        .head_vld  (head_vld),
        .head_dat  (head_dat),
        .push_drop (push_drop)
    );

    assign ack_timeout = (state == WAIT_ACK) & ~spi_busy_in & (ack_cnt == TW'(ACK_TIMEOUT - 1));
    assign xfer_done   = (state == WAIT_DONE) & ~spi_busy_in;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE:      if (head_vld && !spi_busy_in) state_nxt = ISSUE;
            ISSUE: begin
                pop       = 1'b1;
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (spi_busy_in)      state_nxt = WAIT_DONE;
                else if (ack_timeout) state_nxt = IDLE;
            end
            WAIT_DONE: if (!spi_busy_in) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Trigger and packet are registered on entry to ISSUE so both are valid for the whole ISSUE cycle.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state           <= IDLE;
            ack_cnt         <= '0;
            spi_trigger_out <= 1'b0;
            spi_data_out    <= '0;
            pkt_count_out   <= '0;
            drop_count_out  <= '0;
            ack_err_out     <= 1'b0;
        end else begin
            state           <= state_nxt;
            ack_cnt         <= (state == WAIT_ACK) ? ack_cnt + 1'b1 : '0;
            spi_trigger_out <= (state_nxt == ISSUE);
            if (state_nxt == ISSUE) spi_data_out <= head_dat;
            if (xfer_done)          pkt_count_out <= pkt_count_out + 16'd1;
            if (push_drop && drop_count_out != 8'hFF) drop_count_out <= drop_count_out + 8'd1;
            if (ack_timeout)        ack_err_out <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_packet_scheduler.sv
// Bench for spi_packet_scheduler: directed scenarios plus a random pixel stream against a packet-level model.
`timescale 1ns/1ps

module tb_spi_packet_scheduler;
    localparam int LINES = 6;
    localparam int DW    = 16;
    localparam int PW    = LINES * DW;
    localparam int M_NORMAL = 0;
    localparam int M_HOLD   = 1;
    localparam int M_NOACK  = 2;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          enable_in = 1'b0;
    logic          pixel_valid_in = 1'b0;
    logic [DW-1:0] pixel_data_in = '0;
    logic [10:0]   hcount_in = '0;
    logic [9:0]    vcount_in = '0;
    logic          spi_busy_in;
    logic          spi_trigger_out;
    logic [PW-1:0] spi_data_out;
    logic          frame_start_out;
    logic [15:0]   pkt_count_out;
    logic [7:0]    drop_count_out;
    logic          ack_err_out;

    int total = 0;
    int bad   = 0;
    int trig_cnt = 0;
    int fs_cnt   = 0;
    int snd_mode = M_NORMAL;
    bit rand_dur = 1'b0;

    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] got_q[$];
    logic [PW-1:0] part;
    int part_n    = 0;
    int frame_ctr = 0;
    int pk_exp    = 0;
    int drop_exp  = 0;

    spi_packet_scheduler dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .enable_in       (enable_in),
        .pixel_valid_in  (pixel_valid_in),
        .pixel_data_in   (pixel_data_in),
        .hcount_in       (hcount_in),
        .vcount_in       (vcount_in),
        .spi_busy_in     (spi_busy_in),
        .spi_trigger_out (spi_trigger_out),
        .spi_data_out    (spi_data_out),
        .frame_start_out (frame_start_out),
        .pkt_count_out   (pkt_count_out),
        .drop_count_out  (drop_count_out),
        .ack_err_out     (ack_err_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packet-level model: accepted pixels fill lanes top-down; origin restarts a packet (and queues a header).
    function void model_px(input logic v, input logic e, input logic [10:0] h, input logic [9:0] vc,
                           input logic [DW-1:0] d);
        if (!(v && e && !h[0] && !vc[0])) return;
        if (h == '0 && vc == '0) begin
            part_n = 0;
            part   = '0;
`ifdef PKT_FRAME_HEADER_EN
            exp_q.push_back({{(LINES-1){16'hA5A5}}, 16'(frame_ctr)});
            frame_ctr++;
`endif
        end
        part[PW-1-part_n*DW -: DW] = d;
        part_n++;
        if (part_n == LINES) begin
            exp_q.push_back(part);
            part_n = 0;
        end
    endfunction

    task automatic px(input logic v, input logic e, input logic [10:0] h, input logic [9:0] vc,
                      input logic [DW-1:0] d);
        pixel_valid_in = v;
        enable_in      = e;
        hcount_in      = h;
        vcount_in      = vc;
        pixel_data_in  = d;
        model_px(v, e, h, vc, d);
        @(negedge clk_in);
        pixel_valid_in = 1'b0;
    endtask

    task automatic wait_sent(input int n, input string tag);
        int b;
        b = 2000;
        while (got_q.size() < n && b > 0) begin
            @(negedge clk_in);
            b--;
        end
        chk({tag, "_sent_in_time"}, 128'(got_q.size() >= n), 128'(1));
        repeat (12) @(negedge clk_in);
    endtask

    task automatic cmp_q(input string tag);
        chk({tag, "_pkt_n"}, 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_pkt%0d", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
        pk_exp += exp_q.size();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset(input string tag);
        pixel_valid_in = 1'b0;
        enable_in      = 1'b0;
        hcount_in      = '0;
        vcount_in      = '0;
        pixel_data_in  = '0;
        rst_in         = 1'b0;
        repeat (3) @(negedge clk_in);
        chk({tag, "_trig"},  128'(spi_trigger_out), 128'(0));
        chk({tag, "_data"},  128'(spi_data_out),    128'(0));
        chk({tag, "_fs"},    128'(frame_start_out), 128'(0));
        chk({tag, "_pkt"},   128'(pkt_count_out),   128'(0));
        chk({tag, "_drop"},  128'(drop_count_out),  128'(0));
        chk({tag, "_err"},   128'(ack_err_out),     128'(0));
        rst_in = 1'b1;
        @(negedge clk_in);
        part_n    = 0;
        frame_ctr = 0;
        pk_exp    = 0;
        drop_exp  = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic find_trigger(input string tag);
        int b;
        b = 200;
        while (!spi_trigger_out && b > 0) begin
            @(negedge clk_in);
            b--;
        end
        chk({tag, "_trigger_seen"}, 128'(spi_trigger_out), 128'(1));
    endtask

    // SPI sender stand-in: records every trigger, answers with busy according to snd_mode.
    initial begin
        int            d;
        logic [PW-1:0] cap;
        spi_busy_in = 1'b0;
        forever begin
            @(negedge clk_in);
            if (spi_trigger_out) begin
                trig_cnt++;
                got_q.push_back(spi_data_out);
            end
            if (snd_mode == M_HOLD) spi_busy_in = 1'b1;
            else if (snd_mode == M_NOACK || !spi_trigger_out) spi_busy_in = 1'b0;
            else begin
                cap = spi_data_out;
                d   = rand_dur ? int'($urandom_range(1, 3)) : 2;
                @(negedge clk_in);
                spi_busy_in = 1'b1;
                repeat (d) @(negedge clk_in);
                chk("data_stable_while_busy", 128'(spi_data_out), 128'(cap));
                spi_busy_in = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_in);
            if (frame_start_out) fs_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            t0;
        int            f0;
        logic [PW-1:0] lastp;
        logic          rv;
        logic          re;
        logic [10:0]   rh;
        logic [9:0]    rvc;

        @(negedge clk_in);
        do_reset("rst0");

        // Two packets, sender busy for 2 cycles after each trigger.
        snd_mode = M_NORMAL;
        t0 = trig_cnt;
        for (int i = 1; i <= 12; i++) px(1'b1, 1'b1, 11'(2 * i), 10'd2, 16'(i));
        wait_sent(2, "t1");
        chk("t1_triggers", 128'(trig_cnt - t0), 128'(2));
        chk("t1_pkt0_literal", 128'(got_q[0]), 128'(96'h000100020003000400050006));
        chk("t1_pkt1_literal", 128'(got_q[1]), 128'(96'h00070008000900_0A000B000C));
        cmp_q("t1");
        chk("t1_pkt_count", 128'(pkt_count_out), 128'(2));

        // Sender held busy: six packets into a 4-deep FIFO, the two newest are dropped.
        snd_mode = M_HOLD;
        repeat (2) @(negedge clk_in);
        t0 = trig_cnt;
        for (int i = 0; i < 36; i++) px(1'b1, 1'b1, 11'(2 * (i + 1)), 10'd4, 16'(256 + i));
        repeat (5) @(negedge clk_in);
        drop_exp += 2;
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        chk("t2_drop_count", 128'(drop_count_out), 128'(drop_exp));
        chk("t2_no_trigger_while_busy", 128'(trig_cnt - t0), 128'(0));
        snd_mode = M_NORMAL;
        wait_sent(4, "t2");
        repeat (30) @(negedge clk_in);
        chk("t2_triggers_after_release", 128'(trig_cnt - t0), 128'(4));
        cmp_q("t2");
        chk("t2_pkt_count", 128'(pkt_count_out), 128'(pk_exp));

        // Busy never rises: error flag on cycle 5 after the trigger, packet not counted.
        snd_mode = M_NOACK;
        for (int i = 0; i < LINES; i++) px(1'b1, 1'b1, 11'(2 * (i + 1)), 10'd6, 16'(512 + i));
        find_trigger("t3");
        chk("t3_err_at_trigger", 128'(ack_err_out), 128'(0));
        repeat (4) @(negedge clk_in);
        chk("t3_err_cycle4", 128'(ack_err_out), 128'(0));
        @(negedge clk_in);
        chk("t3_err_cycle5", 128'(ack_err_out), 128'(1));
        chk("t3_pkt_count_unchanged", 128'(pkt_count_out), 128'(pk_exp));
        got_q.delete();
        exp_q.delete();
        snd_mode = M_NORMAL;
        for (int i = 0; i < LINES; i++) px(1'b1, 1'b1, 11'(2 * (i + 1)), 10'd8, 16'(768 + i));
        wait_sent(1, "t3_recover");
        cmp_q("t3_recover");
        chk("t3_pkt_count_after", 128'(pkt_count_out), 128'(pk_exp));
        chk("t3_err_sticky", 128'(ack_err_out), 128'(1));

        // Partial packet discarded by a frame start; origin pixel leads the new packet.
        f0 = fs_cnt;
        for (int i = 0; i < 3; i++) px(1'b1, 1'b1, 11'(2 * (i + 1)), 10'd10, 16'(16'hE000 + i));
        px(1'b1, 1'b1, 11'd0, 10'd0, 16'hF00D);
        chk("t4_fs_pulse", 128'(frame_start_out), 128'(1));
        px(1'b1, 1'b1, 11'd2, 10'd0, 16'hF001);
        chk("t4_fs_one_cycle", 128'(frame_start_out), 128'(0));
        for (int i = 2; i <= 5; i++) px(1'b1, 1'b1, 11'(2 * i), 10'd0, 16'(16'hF000 + i));
        wait_sent(exp_q.size(), "t4");
        lastp = (got_q.size() > 0) ? got_q[got_q.size() - 1] : '0;
        chk("t4_top_lane_origin", 128'(lastp[PW-1 -: DW]), 128'(16'hF00D));
        cmp_q("t4");
        chk("t4_fs_count", 128'(fs_cnt - f0), 128'(1));
        chk("t4_drop_unchanged", 128'(drop_count_out), 128'(drop_exp));

        // Odd coordinates, enable low, valid low: nothing accepted, partial packet held.
        t0 = trig_cnt;
        f0 = fs_cnt;
        px(1'b1, 1'b1, 11'd2, 10'd12, 16'hA001);
        px(1'b1, 1'b1, 11'd4, 10'd12, 16'hA002);
        for (int i = 0; i < 40; i++) begin
            case (i % 4)
                0:       px(1'b1, 1'b1, 11'(2 * i + 1), 10'd12, 16'(i));
                1:       px(1'b1, 1'b1, 11'(2 * i), 10'd13, 16'(i));
                2:       px(1'b1, 1'b0, 11'd0, 10'd0, 16'(i));
                default: px(1'b0, 1'b1, 11'(2 * i), 10'd12, 16'(i));
            endcase
        end
        repeat (20) @(negedge clk_in);
        chk("t5_no_trigger", 128'(trig_cnt - t0), 128'(0));
        chk("t5_no_frame_start", 128'(fs_cnt - f0), 128'(0));
        for (int i = 3; i <= 6; i++) px(1'b1, 1'b1, 11'(2 * i), 10'd12, 16'(16'hA000 + i));
        wait_sent(exp_q.size(), "t5");
        cmp_q("t5");
        chk("t5_pkt_count", 128'(pkt_count_out), 128'(pk_exp));

        // Reset during a transfer clears trigger and packet immediately.
        snd_mode = M_NOACK;
        for (int i = 0; i < LINES; i++) px(1'b1, 1'b1, 11'(2 * (i + 1)), 10'd14, 16'(16'hD000 + i));
        find_trigger("t6");
        #2 rst_in = 1'b0;
        #1;
        chk("t6_async_trig", 128'(spi_trigger_out), 128'(0));
        chk("t6_async_data", 128'(spi_data_out), 128'(0));
        chk("t6_async_err", 128'(ack_err_out), 128'(0));
        do_reset("rst1");

        // Two frames after reset.
        snd_mode = M_NORMAL;
        px(1'b1, 1'b1, 11'd0, 10'd0, 16'hB000);
        for (int i = 1; i < LINES; i++) px(1'b1, 1'b1, 11'(2 * i), 10'd0, 16'(16'hB000 + i));
        px(1'b1, 1'b1, 11'd0, 10'd0, 16'hC000);
        for (int i = 1; i < LINES; i++) px(1'b1, 1'b1, 11'(2 * i), 10'd0, 16'(16'hC000 + i));
        wait_sent(exp_q.size(), "t7");
`ifdef PKT_FRAME_HEADER_EN
        chk("t7_header0", 128'(got_q[0]), 128'(96'hA5A5A5A5A5A5A5A5A5A50000));
        chk("t7_header1", 128'(got_q[2]), 128'(96'hA5A5A5A5A5A5A5A5A5A50001));
`else
        chk("t7_frame_a_top", 128'(got_q[0][PW-1 -: DW]), 128'(16'hB000));
`endif
        cmp_q("t7");
        chk("t7_pkt_count", 128'(pkt_count_out), 128'(pk_exp));

        // Random stream with random busy lengths; low accept rate keeps the FIFO from overflowing.
        rand_dur = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            rv  = 1'($urandom_range(0, 1));
            re  = ($urandom_range(0, 9) != 0);
            rh  = 11'($urandom_range(0, 2047));
            rvc = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 199) == 0) begin
                rh  = '0;
                rvc = '0;
            end
            px(rv, re, rh, rvc, 16'($urandom));
        end
        wait_sent(exp_q.size(), "rand");
        cmp_q("rand");
        chk("rand_pkt_count", 128'(pkt_count_out), 128'(pk_exp));
        chk("rand_drop_count", 128'(drop_count_out), 128'(drop_exp));
        chk("rand_no_ack_err", 128'(ack_err_out), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
